// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// wb_port_arbiter: register-file write-port arbiter, pipeline WB vs buffered
// multicycle results. Optional counters: define WB_PORT_ARBITER_PERF_EN.
// Revision: 1.0
// ============================================================================
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_data,
  output logic                   stall_wb,
  input  logic                   mc_valid,
  output logic                   mc_ready,
  input  logic [4:0]             mc_addr,
  input  logic [31:0]            mc_data,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [31:0]            rf_wdata,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef WB_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            mc_wr_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d, starve_inc;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  dead_q, dead_d;
  logic [4:0]        mem_addr [DEPTH];
  logic [31:0]       mem_data [DEPTH];
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;

  logic              empty, push, pop, grant_wb, squash, fifo_wr;
  logic [4:0]        head_addr;
  logic [31:0]       head_data;
  logic              head_dead;

  assign empty      = (count_q == '0);
  assign mc_ready   = (count_q < CW'(DEPTH));
  assign push       = mc_valid & mc_ready;
  assign stall_wb   = (state_q == ST_FORCE);
  assign head_addr  = mem_addr[rd_ptr_q];
  assign head_data  = mem_data[rd_ptr_q];
  assign head_dead  = dead_q[rd_ptr_q];
  assign starve_inc = starve_q + 1'b1;
  assign squash     = grant_wb & (wb_addr != 5'd0);
  assign fifo_wr    = pop & ~head_dead & (head_addr != 5'd0);

  always_comb begin
    state_d  = ST_NORMAL;
    starve_d = '0;
    grant_wb = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (wb_en) begin
          grant_wb = 1'b1;
        end else if (!empty) begin
          pop = 1'b1;
        end
        if (!empty && !pop) begin
          starve_d = starve_inc;
          if (starve_inc >= SW'(STARVE_MAX)) begin
            state_d = ST_FORCE;
          end
        end
      end
      ST_FORCE: begin
        // An empty FIFO here is unreachable; fall back to NORMAL without a write.
        pop = !empty;
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (squash) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_addr;
      rf_wdata_d = wb_data;
    end else if (fifo_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = head_addr;
      rf_wdata_d = head_data;
    end
  end

  // Stale slots may be marked dead harmlessly; a push always writes a live entry.
  always_comb begin
    dead_d = dead_q;
    if (squash) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_addr[i] == wb_addr) begin
          dead_d[i] = 1'b1;
        end
      end
    end
    if (push) begin
      dead_d[wr_ptr_q] = 1'b0;
    end
  end

  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= mc_addr;
      mem_data[wr_ptr_q] <= mc_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_NORMAL;
      starve_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      dead_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      dead_q     <= dead_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;

`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0] stall_cnt_q, mc_wr_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      mc_wr_cnt_q <= '0;
    end else begin
      if (stall_wb) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (fifo_wr)  mc_wr_cnt_q <= mc_wr_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign mc_wr_cnt = mc_wr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter
// against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_wb_port_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_en = 1'b0;
  logic [4:0]    wb_addr = '0;
  logic [31:0]   wb_data = '0;
  logic          stall_wb;
  logic          mc_valid = 1'b0;
  logic          mc_ready;
  logic [4:0]    mc_addr = '0;
  logic [31:0]   mc_data = '0;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [CW-1:0] fifo_count;
`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   mc_wr_cnt;
`endif

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .stall_wb   (stall_wb),
    .mc_valid   (mc_valid),
    .mc_ready   (mc_ready),
    .mc_addr    (mc_addr),
    .mc_data    (mc_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fifo_count (fifo_count)
`ifdef WB_PORT_ARBITER_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .mc_wr_cnt  (mc_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: FIFO as a queue of entries, starvation as a plain count.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          dead;
  } ent_t;

  ent_t        q[$];
  int          starve;
  bit          frc;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_stall_cnt;
  int          m_mcwr_cnt;
  logic [31:0] rf_dut [32];

  function automatic void model_reset();
    q.delete();
    starve      = 0;
    frc         = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_data      = '0;
    m_stall_cnt = 0;
    m_mcwr_cnt  = 0;
  endfunction

  function automatic void model_step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                     input logic mv, input logic [4:0] ma, input logic [31:0] md);
    int   sz;
    bit   do_push, gp, gf;
    ent_t e;
    sz      = q.size();
    do_push = mv && (sz < DEPTH);
    gp      = 1'b0;
    gf      = 1'b0;
    if (frc)     gf = (sz > 0);
    else if (we) gp = 1'b1;
    else         gf = (sz > 0);
    if (frc) m_stall_cnt++;
    m_we = 1'b0;
    if (gp && wa != 5'd0) begin
      m_we = 1'b1; m_addr = wa; m_data = wd;
      foreach (q[i]) if (q[i].a == wa) q[i].dead = 1'b1;
    end
    if (gf) begin
      e = q.pop_front();
      if (!e.dead && e.a != 5'd0) begin
        m_we = 1'b1; m_addr = e.a; m_data = e.d; m_mcwr_cnt++;
      end
    end
    if (do_push) begin
      e.a = ma; e.d = md; e.dead = 1'b0;
      q.push_back(e);
    end
    if (frc || gf || sz == 0) begin
      starve = 0;
      frc    = 1'b0;
    end else begin
      starve++;
      frc = (starve >= STARVE_MAX);
    end
  endfunction

  task automatic check_outputs(input string tag);
    chk_eq({tag, ".rf_we"},    rf_we,      m_we);
    chk_eq({tag, ".rf_waddr"}, rf_waddr,   m_addr);
    chk_eq({tag, ".rf_wdata"}, rf_wdata,   m_data);
    chk_eq({tag, ".stall_wb"}, stall_wb,   frc);
    chk_eq({tag, ".mc_ready"}, mc_ready,   q.size() < DEPTH);
    chk_eq({tag, ".count"},    fifo_count, q.size());
`ifdef WB_PORT_ARBITER_PERF_EN
    chk_eq({tag, ".stall_cnt"}, stall_cnt, m_stall_cnt);
    chk_eq({tag, ".mc_wr_cnt"}, mc_wr_cnt, m_mcwr_cnt);
`endif
  endtask

  // Called at a falling edge: drive, let the rising edge happen, check at the next fall.
  task automatic cycle(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_en = we; wb_addr = wa; wb_data = wd;
    mc_valid = mv; mc_addr = ma; mc_data = md;
    @(posedge clk);
    model_step(we, wa, wd, mv, ma, md);
    @(negedge clk);
    if (rf_we === 1'b1) rf_dut[rf_waddr] = rf_wdata;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic async_reset(input string tag);
    wb_en = 1'b0; mc_valid = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1 check_outputs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic        h_we;
    logic [4:0]  h_wa;
    logic [31:0] h_wd;
    int          wb_pct, mc_pct, guard;

    model_reset();
    foreach (rf_dut[i]) rf_dut[i] = '0;
    @(negedge clk);
    check_outputs("reset");
    chk_eq("reset.ready_const", mc_ready, 1'b1);
    chk_eq("reset.we_const", rf_we, 1'b0);
    rst = 1'b1;

    // Pipeline-only write
    cycle("pipe", 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    chk_eq("pipe.we_const", rf_we, 1'b1);
    chk_eq("pipe.addr_const", rf_waddr, 5'd5);
    chk_eq("pipe.data_const", rf_wdata, 32'h1234_5678);
    chk_eq("pipe.stall_const", stall_wb, 1'b0);
    idle("pipe_idle");

    // Idle-slot drain
    cycle("drain_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA);
    chk_eq("drain.count1", fifo_count, 1);
    idle("drain_pop");
    chk_eq("drain.we_const", rf_we, 1'b1);
    chk_eq("drain.addr_const", rf_waddr, 5'd7);
    chk_eq("drain.data_const", rf_wdata, 32'hA);
    chk_eq("drain.count0", fifo_count, 0);

    // Starvation with continuous pipeline traffic
    cycle("starve_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    for (int i = 1; i <= STARVE_MAX; i++) begin
      cycle("starve_run", 1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 32'd0);
      chk_eq("starve.stall_const", stall_wb, (i == STARVE_MAX));
    end
    cycle("starve_force", 1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 32'd0);
    chk_eq("starve.mc_addr", rf_waddr, 5'd3);
    chk_eq("starve.stall_off", stall_wb, 1'b0);
    cycle("starve_after", 1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 32'd0);
    chk_eq("starve.pipe_addr", rf_waddr, 5'd1);

    // Full FIFO
    cycle("full_p1", 1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    cycle("full_p2", 1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66);
    cycle("full_p3", 1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 32'h88);
    chk_eq("full.ready_const", mc_ready, 1'b0);
    chk_eq("full.count_const", fifo_count, 2);
    for (int i = 0; i < 8; i++) idle("full_drain");
    chk_eq("full.empty", fifo_count, 0);

    // WAW squash
    foreach (rf_dut[i]) rf_dut[i] = '0;
    cycle("waw_push", 1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h1);
    cycle("waw_pipe", 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
    idle("waw_pop");
    chk_eq("waw.we_const", rf_we, 1'b0);
    chk_eq("waw.reg9", rf_dut[9], 32'h2);
    idle("waw_idle");

    // Async reset with a full FIFO and FORCE pending
    cycle("ar_p1", 1'b1, 5'd2, 32'hBEEF, 1'b1, 5'd10, 32'hA0);
    cycle("ar_p2", 1'b1, 5'd2, 32'hBEEF, 1'b1, 5'd11, 32'hB0);
    guard = 0;
    while (!frc && guard < 20) begin
      cycle("ar_run", 1'b1, 5'd2, 32'hBEEF, 1'b0, 5'd0, 32'd0);
      guard++;
    end
    chk_eq("ar.force_reached", frc, 1'b1);
    async_reset("ar_async");
    chk_eq("ar.count_const", fifo_count, 0);
    chk_eq("ar.data_const", rf_wdata, 32'd0);
    for (int i = 0; i < 4; i++) idle("ar_post");
    cycle("x0_push", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    idle("x0_pop");
    chk_eq("x0.we_const", rf_we, 1'b0);
    chk_eq("x0.count_const", fifo_count, 0);

    // Randomized traffic across several load regimes
    h_we = 1'b0; h_wa = '0; h_wd = '0;
    for (int n = 0; n < 3000; n++) begin
      case ((n / 400) % 4)
        0:       begin wb_pct = 30;  mc_pct = 40; end
        1:       begin wb_pct = 85;  mc_pct = 60; end
        2:       begin wb_pct = 100; mc_pct = 30; end
        default: begin wb_pct = 60;  mc_pct = 90; end
      endcase
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rnd_arst");
        h_we = 1'b0;
      end else begin
        if (!frc) begin
          h_we = ($urandom_range(0, 99) < wb_pct);
          h_wa = 5'($urandom_range(0, 3));
          h_wd = $urandom;
        end
        cycle("rnd", h_we, h_wa, h_wd,
              ($urandom_range(0, 99) < mc_pct), 5'($urandom_range(0, 3)), $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
